// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the pipelined adder tree.
// All functions are only ever evaluated at elaboration time to size
// levels, operand widths and the output bus.
package adder_tree_pkg;

   // Smallest r such that 2**r >= n; 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Number of terms left after pairing up n terms, with an odd one carried.
   function automatic int half_up(input int n);
      return (n + 1) / 2;
   endfunction

   // Number of reduction levels; a single operand still gets one register stage.
   function automatic int levels(input int n);
      int c;
      c = clog2(n);
      return (c < 1) ? 1 : c;
   endfunction

   // Number of terms entering level k (level 0 sees all n operands).
   function automatic int terms_at_level(input int n, input int k);
      int t;
      t = n;
      for (int i = 0; i < 31; i++) begin
         if (i < k) begin
            t = half_up(t);
         end
      end
      return t;
   endfunction

   // Width that holds the exact sum of n operands of w bits in either mode.
   function automatic int out_width(input int w, input int n);
      return w + clog2(n);
   endfunction

endpackage

// File: rtl/adder_tree_pipe_level.sv
// One registered reduction level of the adder tree: adds neighbouring terms
// pairwise, carries an odd leftover term through unchanged, and moves the
// beat's valid and signed-mode bits along with the data.
module adder_tree_level
   import adder_tree_pkg::*;
#(
   parameter int IN_TERMS = 2,
   parameter int IN_W     = 8,
   parameter int OUT_W    = IN_W + 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                en_i,
   input  logic                                valid_i,
   input  logic                                signed_i,
   input  logic [IN_TERMS*IN_W-1:0]            data_i,
   output logic                                valid_o,
   output logic                                signed_o,
   output logic [half_up(IN_TERMS)*OUT_W-1:0]  data_o
);

   localparam int OUT_TERMS = half_up(IN_TERMS);

   logic [OUT_TERMS*OUT_W-1:0] data_d;
   logic [OUT_TERMS*OUT_W-1:0] data_q;
   logic                       valid_q;
   logic                       signed_q;

   // Sign- or zero-extend a term to the level output width; narrowing only
   // happens on the last level, where the value is known to fit.
   function automatic logic [OUT_W-1:0] extendTerm(input logic [IN_W-1:0] v, input logic s);
      return OUT_W'($signed({s & v[IN_W-1], v}));
   endfunction

   // Pairwise sums, with the odd leftover term forwarded in the last slot.
   always_comb begin
      data_d = '0;
      for (int i = 0; i < IN_TERMS / 2; i++) begin
         data_d[i*OUT_W +: OUT_W] = extendTerm(data_i[(2*i)*IN_W +: IN_W], signed_i)
                                  + extendTerm(data_i[(2*i+1)*IN_W +: IN_W], signed_i);
      end
      if (IN_TERMS % 2 == 1) begin
         data_d[(OUT_TERMS-1)*OUT_W +: OUT_W] =
            extendTerm(data_i[(IN_TERMS-1)*IN_W +: IN_W], signed_i);
      end
   end

   // Stage register; holds everything while the pipeline is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         valid_q  <= 1'b0;
         signed_q <= 1'b0;
      end else if (en_i) begin
         data_q   <= data_d;
         valid_q  <= valid_i;
         signed_q <= signed_i;
      end
   end

   assign data_o   = data_q;
   assign valid_o  = valid_q;
   assign signed_o = signed_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined N-input adder tree with valid/ready streaming and a per-beat
// signed/unsigned mode. Every reduction level is registered; a single global
// enable stalls all stages together when the output is held.
module adder_tree_pipe
   import adder_tree_pkg::*;
#(
   parameter  int WIDTH = 23,
   parameter  int N     = 9,
   localparam int OW    = out_width(WIDTH, N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OW-1:0]      out_sum
);

   localparam int L = levels(N);

   logic stageEn;
   logic unusedLastMode;

   assign stageEn  = !out_valid || out_ready;
   assign in_ready = stageEn;

   for (genvar k = 0; k < L; k++) begin : gLevel
      localparam int IN_TERMS  = terms_at_level(N, k);
      localparam int IN_W      = WIDTH + 1 + k;
      localparam int OUT_W     = (k == L - 1) ? OW : IN_W + 1;
      localparam int OUT_TERMS = half_up(IN_TERMS);

      logic [IN_TERMS*IN_W-1:0]   levelData;
      logic                       levelValid;
      logic                       levelMode;
      logic [OUT_TERMS*OUT_W-1:0] stageData;
      logic                       stageValid;
      logic                       stageMode;

      if (k == 0) begin : gEntry
         // Widen each raw operand by one bit according to the beat's mode.
         always_comb begin
            levelData = '0;
            for (int i = 0; i < N; i++) begin
               levelData[i*IN_W +: IN_W] = {in_signed & in_data[i*WIDTH + WIDTH - 1],
                                            in_data[i*WIDTH +: WIDTH]};
            end
         end
         assign levelValid = in_valid;
         assign levelMode  = in_signed;
      end else begin : gChain
         assign levelData  = gLevel[k-1].stageData;
         assign levelValid = gLevel[k-1].stageValid;
         assign levelMode  = gLevel[k-1].stageMode;
      end

      adder_tree_level #(
         .IN_TERMS (IN_TERMS),
         .IN_W     (IN_W),
         .OUT_W    (OUT_W)
      ) uLevel (
         .clk      (clk),
         .rst_n    (rst_n),
         .en_i     (stageEn),
         .valid_i  (levelValid),
         .signed_i (levelMode),
         .data_i   (levelData),
         .valid_o  (stageValid),
         .signed_o (stageMode),
         .data_o   (stageData)
      );
   end

   assign out_valid      = gLevel[L-1].stageValid;
   assign out_sum        = gLevel[L-1].stageData;
   assign unusedLastMode = gLevel[L-1].stageMode;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe at WIDTH=23, N=9 (L=4, OW=27).
// The driver pushes the expected sum of each accepted beat; the monitor on
// the falling edge compares whatever the DUT presents against the queue head.
module tb_adder_tree_pipe;

   localparam int WIDTH = 23;
   localparam int N     = 9;
   localparam int L     = 4;
   localparam int OW    = 27;

   typedef struct {
      logic [OW-1:0] sum;
      int            acceptEdge;
      bit            checkLatency;
   } expect_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [N*WIDTH-1:0] in_data;
   logic               in_signed;
   logic               out_valid;
   logic               out_ready;
   logic [OW-1:0]      out_sum;

   expect_t scoreboard[$];
   int      checks      = 0;
   int      failures    = 0;
   int      cycleCount  = 0;
   int      stallCount  = 0;
   bit      randomReady = 1'b0;
   bit      latencyMode = 1'b1;
   bit      frontSeen   = 1'b0;

   adder_tree_pipe #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_signed (in_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum)
   );

   // Free-running clock and edge counter used for latency measurement.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   function automatic logic [N*WIDTH-1:0] fill(input logic [WIDTH-1:0] v);
      logic [N*WIDTH-1:0] r;
      for (int i = 0; i < N; i++) r[i*WIDTH +: WIDTH] = v;
      return r;
   endfunction

   function automatic logic [OW-1:0] refSum(input logic [N*WIDTH-1:0] d, input logic m);
      longint        acc;
      logic [WIDTH-1:0] op;
      acc = 0;
      for (int i = 0; i < N; i++) begin
         op = d[i*WIDTH +: WIDTH];
         if (m) acc += longint'($signed(op));
         else   acc += longint'(op);
      end
      return acc[OW-1:0];
   endfunction

   // Present one beat until accepted, then record its expected result.
   task automatic applyStimulus(input logic [N*WIDTH-1:0] d, input logic m, input logic [OW-1:0] exp);
      bit      accepted = 1'b0;
      int      edgeNo   = 0;
      expect_t e;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_signed = m;
      for (int tries = 0; tries < 100 && !accepted; tries++) begin
         #1;
         accepted = in_ready;
         edgeNo   = cycleCount + 1;
         @(posedge clk);
         if (!accepted) @(negedge clk);
      end
      if (!accepted) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      end else begin
         e.sum          = exp;
         e.acceptEdge   = edgeNo;
         e.checkLatency = latencyMode;
         scoreboard.push_back(e);
      end
   endtask

   task automatic idleInput();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited = 0;
      while (scoreboard.size() != 0 && waited < 500) begin
         @(posedge clk);
         waited++;
      end
      if (scoreboard.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_timeout: %0d beats outstanding, required 0", scoreboard.size());
      end
      repeat (3) @(posedge clk);
   endtask

   // Monitor: compare presented output with queue head, then pick out_ready.
   task automatic checkOutput();
      if (out_valid && !out_ready) begin
         checks++;
         if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL in_ready_stall: got %b, required 0", in_ready);
         end
      end
      if (out_valid) begin
         checks++;
         if (scoreboard.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_output: got sum %h, required no output", out_sum);
         end else begin
            if (out_sum !== scoreboard[0].sum) begin
               failures++;
               $display("[TB] FAIL sum: got %h, required %h", out_sum, scoreboard[0].sum);
            end
            if (!frontSeen && scoreboard[0].checkLatency) begin
               checks++;
               if (cycleCount != scoreboard[0].acceptEdge + L - 1) begin
                  failures++;
                  $display("[TB] FAIL latency: got edge %0d, required edge %0d",
                           cycleCount, scoreboard[0].acceptEdge + L - 1);
               end
            end
            frontSeen = 1'b1;
         end
      end
      if (randomReady) begin
         out_ready = ($urandom_range(0, 3) != 0);
      end else if (stallCount > 0) begin
         out_ready = 1'b0;
         if (out_valid) stallCount--;
      end else begin
         out_ready = 1'b1;
      end
      if (out_valid && out_ready && scoreboard.size() > 0) begin
         scoreboard.delete(0);
         frontSeen = 1'b0;
      end
   endtask

   always @(negedge clk) if (rst_n) checkOutput();

   initial begin
      logic [N*WIDTH-1:0] d;
      logic               m;
      logic [WIDTH-1:0]   op;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_signed = 1'b0;
      out_ready = 1'b1;
      #12;
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid); end
      if (out_sum !== '0)     begin failures++; $display("[TB] FAIL reset_out_sum: got %h, required 0", out_sum); end
      if (in_ready !== 1'b1)  begin failures++; $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;

      // Unsigned maximum and signed extremes.
      applyStimulus(fill(23'h7FFFFF), 1'b0, 27'h47FFFF7);
      idleInput();
      drain();
      applyStimulus(fill(23'h400000), 1'b1, 27'h5C00000);
      applyStimulus(fill(23'h7FFFFF), 1'b1, 27'h7FFFFF7);
      applyStimulus(fill(23'h3FFFFF), 1'b1, 27'h23FFFF7);
      applyStimulus(fill(23'h000000), 1'b1, 27'h0000000);
      for (int i = 0; i < N; i++) d[i*WIDTH +: WIDTH] = WIDTH'(i);
      applyStimulus(d, 1'b0, 27'd36);
      idleInput();
      drain();

      // Back-to-back beats alternating signed/unsigned mode.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(fill(23'h7FFFFF), i[0], i[0] ? 27'h7FFFFF7 : 27'h47FFFF7);
      end
      idleInput();
      drain();

      // Backpressure: five stalled cycles with a continuous input stream.
      latencyMode = 1'b0;
      stallCount  = 5;
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(fill(WIDTH'(k)), 1'b0, OW'(9 * k));
      end
      idleInput();
      drain();
      latencyMode = 1'b1;

      // Reset with beats in flight; nothing stale may come out afterwards.
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(fill(WIDTH'(k)), 1'b0, OW'(9 * k));
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush_valid: got %b, required 0", out_valid); end
      if (in_ready !== 1'b1)  begin failures++; $display("[TB] FAIL reset_flush_ready: got %b, required 1", in_ready); end
      in_valid = 1'b0;
      scoreboard.delete();
      frontSeen = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus(fill(23'h000001), 1'b0, 27'h0000009);
      idleInput();
      drain();

      // Random operands drawn from corner and random values, random mode and ready.
      randomReady = 1'b1;
      latencyMode = 1'b0;
      for (int b = 0; b < 300; b++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0:       op = '0;
               1:       op = {WIDTH{1'b1}};
               2:       op = {1'b1, {(WIDTH-1){1'b0}}};
               default: op = WIDTH'($urandom);
            endcase
            d[i*WIDTH +: WIDTH] = op;
         end
         m = 1'($urandom_range(0, 1));
         applyStimulus(d, m, refSum(d, m));
         if ($urandom_range(0, 3) == 0) idleInput();
      end
      idleInput();
      randomReady = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
